iob_merge_rr: RTL and testbench

- N-master to 1-slave merge for the IOb native bus, with round-robin arbitration and response routing back to the granted master.
- It is the counterpart to iob_split. Instruction and data requests that leave the split stage, for example int_mem_i_req and int_mem_d_req, are merged here onto a single-ported memory or peripheral.
- Exactly one transaction is in flight at a time. Fairness is guaranteed by a rotating priority pointer.

---
 rtl/iob_merge_rr_pkg.sv | 28 ++
 rtl/iob_merge_rr_prio.sv | 32 +++
 rtl/iob_merge_rr.sv | 129 ++++++++++++
 tb/tb_iob_merge_rr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_merge_rr_pkg.sv
// Shared definitions for the IOb N-to-1 round-robin merge: bus field
// widths, FSM state encoding and the rotating-pointer increment helper.
package iob_merge_rr_pkg;

    // Width of one request slice {valid, addr, wdata, wstrb}.
    function automatic int unsigned iob_req_w(input int unsigned addr_w,
                                              input int unsigned data_w);
        return 32'd1 + addr_w + data_w + (data_w / 32'd8);
    endfunction

    // Width of one response slice {rdata, ready}.
    function automatic int unsigned iob_resp_w(input int unsigned data_w);
        return data_w + 32'd1;
    endfunction

    // Advance a master index by one, wrapping at n.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                                input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

    // One transaction in flight at most: either arbitrating or waiting on ready.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } merge_state_e;

endpackage

// File: rtl/iob_merge_rr_prio.sv
// Combinational rotating priority encoder: picks the first asserted request
// starting at index ptr and wrapping modulo N. Reusable by other arbiters.
module iob_merge_rr_prio #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt,
    output logic             any
);

    int   dist_v;
    int   best_v;
    logic hit_v;

    // Keep the requester with the smallest rotational distance from ptr.
    always_comb begin
        gnt    = {SEL_W{1'b0}};
        any    = |req;
        best_v = N;
        dist_v = 0;
        hit_v  = 1'b0;
        for (int j = 0; j < N; j++) begin
            dist_v = (j + N - int'(ptr)) % N;
            hit_v  = req[j] && (dist_v < best_v);
            gnt    = hit_v ? SEL_W'(j) : gnt;
            best_v = hit_v ? dist_v : best_v;
        end
    end

endmodule

// File: rtl/iob_merge_rr.sv
// N-master to 1-slave IOb merge. Round-robin arbitration with a rotating
// pointer, one transaction in flight, zero added latency on the request
// path and the slave response routed only to the active master.
module iob_merge_rr
    import iob_merge_rr_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int REQ_W     = int'(iob_req_w(ADDR_W, DATA_W)),
    localparam int RESP_W    = int'(iob_resp_w(DATA_W)),
    localparam int SEL_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp
);

    merge_state_e      state_r;
    merge_state_e      state_nxt_s;
    logic [SEL_W-1:0]  ptr_r;
    logic [SEL_W-1:0]  ptr_nxt_s;
    logic [SEL_W-1:0]  grant_r;
    logic [SEL_W-1:0]  grant_nxt_s;

    logic [N_MASTERS-1:0] valid_vec_s;
    logic [REQ_W-1:0]     req_arr_s [N_MASTERS];
    logic [SEL_W-1:0]     prio_gnt_s;
    logic                 prio_any_s;
    logic [SEL_W-1:0]     active_gnt_s;
    logic                 active_s;
    logic                 s_ready_s;

    assign s_ready_s = s_resp[0];

    // Unpack the master request bus and gather the valid bits (MSB of each slice).
    for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
        assign req_arr_s[k]   = m_req[k*REQ_W +: REQ_W];
        assign valid_vec_s[k] = m_req[k*REQ_W + REQ_W - 1];
    end

    iob_merge_rr_prio #(
        .N     (N_MASTERS),
        .SEL_W (SEL_W)
    ) u_prio (
        .req (valid_vec_s),
        .ptr (ptr_r),
        .gnt (prio_gnt_s),
        .any (prio_any_s)
    );

    // Arbitration FSM: selects the active master and computes next state/pointer.
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        grant_nxt_s  = grant_r;
        active_gnt_s = grant_r;
        active_s     = 1'b0;
        if (rst) begin
            // Outputs stay quiet while reset is held; an in-flight transfer is dropped.
            active_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    active_gnt_s = prio_gnt_s;
                    active_s     = prio_any_s;
                    if (prio_any_s) begin
                        if (s_ready_s) begin
                            ptr_nxt_s   = SEL_W'(rr_wrap_inc(32'(prio_gnt_s), N_MASTERS));
                            state_nxt_s = ST_IDLE;
                        end else begin
                            grant_nxt_s = prio_gnt_s;
                            state_nxt_s = ST_BUSY;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Grant is frozen until the slave answers.
                    active_gnt_s = grant_r;
                    active_s     = 1'b1;
                    if (s_ready_s) begin
                        ptr_nxt_s   = SEL_W'(rr_wrap_inc(32'(grant_r), N_MASTERS));
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, pointer and frozen-grant registers; the pointer moves only on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {SEL_W{1'b0}};
            grant_r <= {SEL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            grant_r <= grant_nxt_s;
        end
    end

    // Request path: forward the active master's slice untouched, otherwise all zero.
    always_comb begin
        s_req = {REQ_W{1'b0}};
        if (active_s) begin
            s_req = req_arr_s[active_gnt_s];
        end else begin
            s_req = {REQ_W{1'b0}};
        end
    end

    // Response path: only the active master sees rdata and ready.
    for (genvar k = 0; k < N_MASTERS; k++) begin : g_resp
        assign m_resp[k*RESP_W +: RESP_W] =
            (active_s && (active_gnt_s == SEL_W'(k))) ? s_resp : {RESP_W{1'b0}};
    end

endmodule

// File: tb/tb_iob_merge_rr.sv
// Self-checking bench for iob_merge_rr (2 masters): directed vector table,
// a fairness sequence and randomized traffic against a behavioural model.
module tb_iob_merge_rr;

    localparam int N      = 2;
    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    logic                  clk;
    logic                  rst;
    logic [N*REQ_W-1:0]    m_req;
    logic [N*RESP_W-1:0]   m_resp;
    logic [REQ_W-1:0]      s_req;
    logic [RESP_W-1:0]     s_resp;

    int n_vec = 0;
    int n_err = 0;

    iob_merge_rr #(
        .N_MASTERS (N),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string              name;
        logic               r;
        logic [REQ_W-1:0]   m0;
        logic [REQ_W-1:0]   m1;
        logic               rdy;
        logic [31:0]        rdata;
        logic [REQ_W-1:0]   exp_s;
        logic [N*RESP_W-1:0] exp_r;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [REQ_W-1:0] rq(input logic v, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    function automatic logic [N*RESP_W-1:0] resp_for(input int m, input logic [31:0] rd,
                                                     input logic rdy);
        logic [N*RESP_W-1:0] r;
        r = '0;
        r[m*RESP_W +: RESP_W] = {rd, rdy};
        return r;
    endfunction

    task automatic add(input string nm, input logic r, input logic [REQ_W-1:0] a0,
                       input logic [REQ_W-1:0] a1, input logic rdy, input logic [31:0] rd,
                       input logic [REQ_W-1:0] es, input logic [N*RESP_W-1:0] er);
        vec_t v;
        v.name = nm; v.r = r; v.m0 = a0; v.m1 = a1; v.rdy = rdy; v.rdata = rd;
        v.exp_s = es; v.exp_r = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [REQ_W-1:0] a0,
                         input logic [REQ_W-1:0] a1, input logic rdy, input logic [31:0] rd);
        rst    = r;
        m_req  = {a1, a0};
        s_resp = {rd, rdy};
    endtask

    task automatic check_out(input string nm, input logic [REQ_W-1:0] es,
                             input logic [N*RESP_W-1:0] er);
        n_vec++;
        if (s_req !== es) begin
            n_err++;
            $display("FAIL %s s_req got %h want %h", nm, s_req, es);
        end
        n_vec++;
        if (m_resp !== er) begin
            n_err++;
            $display("FAIL %s m_resp got %h want %h", nm, m_resp, er);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, '0, 1'b0, 32'h0);
        next_cycle();
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, 32'h0);
    endtask

    logic [REQ_W-1:0] ra, rb, rw, rc, rd, rz, f0, f1;

    // Random-traffic model state.
    logic             pend  [N];
    logic [REQ_W-1:0] rq_a  [N];
    int               mdl_ptr;
    int               mdl_owner;

    initial begin
        drive(1'b1, '0, '0, 1'b0, 32'h0);
        ra = rq(1'b1, 32'h0000_1000, 32'h0, 4'h0);
        rb = rq(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        rw = rq(1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011);
        rc = rq(1'b1, 32'h0000_0300, 32'h0, 4'h0);
        rd = rq(1'b1, 32'h0000_0400, 32'h0000_0055, 4'hF);
        rz = '0;

        add("rst_hold0",     1'b1, ra, rz, 1'b0, 32'h0, rz, '0);
        add("rst_hold1",     1'b1, ra, rz, 1'b0, 32'h0, rz, '0);
        add("rst_hold2",     1'b1, ra, rz, 1'b0, 32'h0, rz, '0);
        add("rst_release",   1'b0, ra, rz, 1'b0, 32'h0, ra, '0);
        add("m0_done",       1'b0, ra, rz, 1'b1, 32'h1111_1111, ra, resp_for(0, 32'h1111_1111, 1'b1));
        add("zw_read_m1",    1'b0, rz, rb, 1'b1, 32'hDEAD_BEEF, rb, resp_for(1, 32'hDEAD_BEEF, 1'b1));
        add("wr_pass",       1'b0, rz, rw, 1'b0, 32'h0, rw, '0);
        add("wr_done",       1'b0, rz, rw, 1'b1, 32'hCAFE_F00D, rw, resp_for(1, 32'hCAFE_F00D, 1'b1));
        add("idle_no_leak",  1'b0, rz, rz, 1'b0, 32'h5555_5555, rz, '0);
        add("cont_wait0",    1'b0, rc, rd, 1'b0, 32'h0, rc, '0);
        add("cont_wait1",    1'b0, rc, rd, 1'b0, 32'h0, rc, '0);
        add("cont_wait2",    1'b0, rc, rd, 1'b0, 32'h0, rc, '0);
        add("cont_m0_done",  1'b0, rc, rd, 1'b1, 32'hA5A5_A5A5, rc, resp_for(0, 32'hA5A5_A5A5, 1'b1));
        add("cont_m1_grant", 1'b0, rz, rd, 1'b0, 32'h0, rd, '0);
        add("cont_m1_done",  1'b0, rz, rd, 1'b1, 32'h0000_0042, rd, resp_for(1, 32'h0000_0042, 1'b1));
        add("zw_both_m0",    1'b0, rc, rd, 1'b1, 32'h0000_0077, rc, resp_for(0, 32'h0000_0077, 1'b1));
        add("zw_both_m1",    1'b0, rc, rd, 1'b1, 32'h0000_0088, rd, resp_for(1, 32'h0000_0088, 1'b1));
        add("pre_rst_m0",    1'b0, rc, rz, 1'b1, 32'h0000_0005, rc, resp_for(0, 32'h0000_0005, 1'b1));
        add("busy_m1",       1'b0, rz, rd, 1'b0, 32'h0, rd, '0);
        add("busy_m1_rdata", 1'b0, rz, rd, 1'b0, 32'h0BAD_0BAD, rd, resp_for(1, 32'h0BAD_0BAD, 1'b0));
        add("rst_mid_busy",  1'b1, rc, rd, 1'b1, 32'h0000_0099, rz, '0);
        add("post_rst_ptr0", 1'b0, rc, rd, 1'b0, 32'h0, rc, '0);
        add("post_rst_done", 1'b0, rc, rd, 1'b1, 32'h0000_1234, rc, resp_for(0, 32'h0000_1234, 1'b1));
        add("post_rst_m1",   1'b0, rz, rd, 1'b1, 32'h0000_4321, rd, resp_for(1, 32'h0000_4321, 1'b1));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].m0, tbl[i].m1, tbl[i].rdy, tbl[i].rdata);
            @(negedge clk);
            check_out(tbl[i].name, tbl[i].exp_s, tbl[i].exp_r);
            next_cycle();
        end

        // Fairness: both masters request continuously, slave answers one cycle late.
        begin
            int cnt0;
            int cnt1;
            cnt0 = 0;
            cnt1 = 0;
            f0 = rq(1'b1, 32'h0000_0500, 32'h0, 4'h0);
            f1 = rq(1'b1, 32'h0000_0600, 32'h0, 4'h0);
            do_reset();
            for (int t = 0; t < 10; t++) begin
                drive(1'b0, f0, f1, 1'b0, 32'h0);
                @(negedge clk);
                check_out("fair_req", (t % 2 == 0) ? f0 : f1, '0);
                next_cycle();
                drive(1'b0, f0, f1, 1'b1, 32'(t + 1));
                @(negedge clk);
                check_out("fair_resp", (t % 2 == 0) ? f0 : f1, resp_for(t % 2, 32'(t + 1), 1'b1));
                cnt0 += int'(m_resp[0]);
                cnt1 += int'(m_resp[RESP_W]);
                next_cycle();
            end
            n_vec++;
            if (cnt0 != 5) begin
                n_err++;
                $display("FAIL fair_cnt_m0 got %0d want 5", cnt0);
            end
            n_vec++;
            if (cnt1 != 5) begin
                n_err++;
                $display("FAIL fair_cnt_m1 got %0d want 5", cnt1);
            end
        end

        // Randomized traffic against a transaction-level model.
        do_reset();
        mdl_ptr   = 0;
        mdl_owner = -1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            rq_a[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic             rst_c;
            logic             rdy_c;
            logic [31:0]      rdata_c;
            int               cur;
            logic [N*REQ_W-1:0] bus;
            logic [REQ_W-1:0] es;
            logic [N*RESP_W-1:0] er;

            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    rq_a[i] = rq(1'b1, $urandom, $urandom,
                                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
                end
            end
            for (int i = 0; i < N; i++) begin
                bus[i*REQ_W +: REQ_W] = pend[i] ? rq_a[i]
                                                : {1'b0, 32'($urandom), 32'($urandom), 4'($urandom)};
            end
            rst_c = ($urandom_range(0, 99) == 0);

            cur = -1;
            if (!rst_c) begin
                if (mdl_owner >= 0) begin
                    cur = mdl_owner;
                end else begin
                    for (int k = N - 1; k >= 0; k--) begin
                        if (pend[(mdl_ptr + k) % N]) cur = (mdl_ptr + k) % N;
                    end
                end
            end
            rdy_c   = (cur >= 0) && ($urandom_range(0, 2) == 0);
            rdata_c = $urandom;

            rst    = rst_c;
            m_req  = bus;
            s_resp = {rdata_c, rdy_c};

            es = (cur >= 0) ? rq_a[cur] : '0;
            er = (cur >= 0) ? resp_for(cur, rdata_c, rdy_c) : '0;
            @(negedge clk);
            check_out("random", es, er);

            if (rst_c) begin
                mdl_ptr   = 0;
                mdl_owner = -1;
            end else if (cur >= 0) begin
                if (rdy_c) begin
                    mdl_ptr   = (cur + 1) % N;
                    mdl_owner = -1;
                    pend[cur] = 1'b0;
                end else begin
                    mdl_owner = cur;
                end
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
